multibyte_add_seq: RTL and testbench
====================================

MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as follows: clk  in  1  clock, all state updates on the rising edge.
REQ-002 rst  in  1  asynchronous active-high reset.
REQ-003 in_valid  in  1  request present.
REQ-004 in_ready  out  1  block can accept a request.
REQ-005 op_a  in  32  operand A.
REQ-006 op_b  in  32  operand B.
REQ-007 carry_in  in  1  add carry-in, ignored when sub=1.
REQ-008 sub  in  1  1 = compute op_a - op_b.
REQ-009 out_valid  out  1  result present.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 sum  out  32  result.
REQ-012 carry_out  out  1  carry out of bit 31; for sub, 1 = no borrow.
REQ-013 overflow  out  1  signed two's-complement overflow.
REQ-014 busy  out  1  high in RUN or DONE.

Function
REQ-015 The block SHALL compute a 32-bit add by reusing one 8-bit adder slice over 4 cycles, low byte first, with the carry chained through a carry register.
REQ-016 States SHALL be IDLE, RUN and DONE.
REQ-017 IDLE -> RUN on in_valid && in_ready; RUN -> DONE after byte 3; DONE -> IDLE on out_ready.
REQ-018 in_ready SHALL be 1 only in IDLE; requests offered in RUN or DONE SHALL be ignored.
REQ-019 On accept, the block SHALL latch op_a; SHALL latch op_b as ~op_b when sub=1; SHALL load the carry register with 1 when sub=1, else with carry_in; SHALL clear the 2-bit byte index.
REQ-020 In RUN cycle k (k = 0..3), the block SHALL add byte k of A, byte k of B' and the carry register, write the result to sum byte k, update the carry register, and increment the index.
REQ-021 The index SHALL wrap from 3 to 0 on the RUN -> DONE transition.
REQ-022 Latency: for an accept at edge N, out_valid SHALL be 1 after edge N+4.
REQ-023 Throughput SHALL be at most one operation per 5 cycles.
REQ-024 In DONE, out_valid SHALL be 1, and sum, carry_out and overflow SHALL hold stable until out_ready=1.
REQ-025 A transfer SHALL occur at an edge where out_valid && out_ready, after which out_valid = 0.
REQ-026 carry_out SHALL be the carry out of byte 3.
REQ-027 overflow SHALL be (A[31] == B'[31]) && (sum[31] != A[31]).
REQ-028 sum, carry_out and overflow SHALL be don't-care-free: they retain their last values when not in DONE, and are zero after reset.
REQ-029 When out_ready=1 and in_valid=1 in the same DONE cycle, the result SHALL transfer, and the new request SHALL be accepted no earlier than the following IDLE cycle.
REQ-030 All arithmetic SHALL be modulo 2^32, and no input SHALL be sampled outside the accept edge.

Reset
REQ-031 While rst=1, the state SHALL be IDLE.
REQ-032 While rst=1: in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0, overflow=0, index=0, carry register=0.
REQ-033 Reset asserted mid-RUN or in DONE SHALL abort the operation with no out_valid pulse.
REQ-034 The first accept SHALL be possible at the first rising edge after rst deasserts.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE/RUN/DONE), WIDTH=32, SLICE=8 and NSLICES=4.
REQ-036 One sub-module, add8_slice, SHALL provide the combinational 8-bit a+b+cin producing an 8-bit sum and cout; it SHALL be instantiated exactly once.
REQ-037 The FSM, operand registers, carry register and byte index SHALL reside in multibyte_add_seq.

Verification
REQ-038 0x000000FF + 0x00000001, cin=0 -> sum=0x00000100, carry_out=0, overflow=0, with out_valid rising 4 edges after accept.
REQ-039 0xFFFFFFFF + 0x00000000, cin=1 -> sum=0x00000000, carry_out=1, overflow=0 (carry ripples through all 4 bytes).
REQ-040 0x7FFFFFFF + 0x00000001, cin=0 -> sum=0x80000000, carry_out=0, overflow=1.
REQ-041 sub: 5 - 7 -> sum=0xFFFFFFFE, carry_out=0; sub: 7 - 5 -> sum=0x00000002, carry_out=1; overflow=0 in both cases.
REQ-042 out_ready held 0 for 3 cycles in DONE -> out_valid=1 and sum unchanged throughout, in_ready=0 and a new in_valid ignored; out_ready=1 -> one transfer, then in_ready=1 on the next cycle.
REQ-043 rst pulsed during the second RUN cycle -> all outputs at reset values immediately, no out_valid pulse; the next request 0x12345678 + 0x11111111 -> 0x23456789.

Source files
------------

// File: rtl/multibyte_add_seq_pkg.sv
// rtl/multibyte_add_seq_pkg.sv - shared types and sizes for the byte-serial 32-bit adder
package multibyte_add_seq_pkg;

    localparam int WIDTH   = 32;
    localparam int SLICE   = 8;
    localparam int NSLICES = WIDTH / SLICE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [SLICE-1:0] get_byte(input logic [WIDTH-1:0] word,
                                                  input logic [1:0]       idx);
        return word[idx*SLICE +: SLICE];
    endfunction

endpackage

// File: rtl/multibyte_add_seq_if.sv
// rtl/multibyte_add_seq_if.sv - request/result handshake bundle for multibyte_add_seq
interface multibyte_add_seq_if;
    import multibyte_add_seq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, busy
    );

endinterface

// File: rtl/multibyte_add_seq_add8_slice.sv
// rtl/multibyte_add_seq_add8_slice.sv - combinational 8-bit a+b+cin slice
module add8_slice
    import multibyte_add_seq_pkg::*;
(
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/multibyte_add_seq.sv
// rtl/multibyte_add_seq.sv - 32-bit add/sub built from one 8-bit slice reused over four cycles
module multibyte_add_seq
    import multibyte_add_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    multibyte_add_seq_if.slave bus
);

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         a_q, a_d;
    logic [WIDTH-1:0]         b_q, b_d;
    logic                     cy_q, cy_d;
    logic [1:0]               idx_q, idx_d;
    logic [WIDTH-SLICE-1:0]   res_q, res_d;
    logic [WIDTH-1:0]         sum_q, sum_d;
    logic                     co_q, co_d;
    logic                     ov_q, ov_d;

    logic [SLICE-1:0]         slice_s;
    logic                     slice_c;

    add8_slice u_slice (
        .a    (get_byte(a_q, idx_q)),
        .b    (get_byte(b_q, idx_q)),
        .cin  (cy_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cy_d    = cy_q;
        idx_d   = idx_q;
        res_d   = res_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    a_d     = bus.op_a;
                    // Subtraction is A + ~B + 1, so carry_in is replaced by the +1.
                    b_d     = bus.sub ? ~bus.op_b : bus.op_b;
                    cy_d    = bus.sub ? 1'b1 : bus.carry_in;
                    idx_d   = 2'd0;
                end
            end
            RUN: begin
                cy_d  = slice_c;
                idx_d = idx_q + 2'd1;
                for (int k = 0; k < NSLICES - 1; k++) begin
                    if (idx_q == 2'(k)) res_d[k*SLICE +: SLICE] = slice_s;
                end
                // Visible result only changes as a whole when the top byte lands.
                if (idx_q == 2'(NSLICES - 1)) begin
                    state_d = DONE;
                    sum_d   = {slice_s, res_q};
                    co_d    = slice_c;
                    ov_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[SLICE-1] != a_q[WIDTH-1]);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            idx_q   <= 2'd0;
            res_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cy_q    <= cy_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ov_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb/tb_multibyte_add_seq.sv - self-checking bench for multibyte_add_seq
module tb_multibyte_add_seq;
    import multibyte_add_seq_pkg::*;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multibyte_add_seq_if bus ();
    multibyte_add_seq dut (.clk(clk), .rst(rst), .bus(bus));

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    res_t q[$];
    logic [31:0] last_sum = '0;
    logic last_co = 1'b0;
    logic last_ov = 1'b0;
    logic exp_valid;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic res_t model(logic [31:0] a, logic [31:0] b, logic cin, logic s);
        res_t        r;
        logic [32:0] t;
        if (s) begin
            r.s  = a - b;
            r.co = (a >= b);
            r.ov = (a[31] != b[31]) && (r.s[31] != a[31]);
        end else begin
            t    = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            r.s  = t[31:0];
            r.co = t[32];
            r.ov = (a[31] == b[31]) && (r.s[31] != a[31]);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.op_a, bus.op_b, bus.carry_in, bus.sub));
                acc_cyc = cyc;
            end
        end
    end

    always @(posedge rst) begin
        q.delete();
        last_sum = '0;
        last_co  = 1'b0;
        last_ov  = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst in_ready", bus.in_ready, 1);
            chk("rst out_valid", bus.out_valid, 0);
            chk("rst busy", bus.busy, 0);
            chk("rst sum", bus.sum, 0);
            chk("rst carry_out", bus.carry_out, 0);
            chk("rst overflow", bus.overflow, 0);
        end else begin
            exp_valid = (q.size() > 0) && ((cyc - acc_cyc) >= 4);
            chk("out_valid", bus.out_valid, exp_valid);
            chk("in_ready", bus.in_ready, q.size() == 0);
            chk("busy", bus.busy, q.size() != 0);
            if (exp_valid) begin
                chk("sum", bus.sum, q[0].s);
                chk("carry_out", bus.carry_out, q[0].co);
                chk("overflow", bus.overflow, q[0].ov);
                last_sum = q[0].s;
                last_co  = q[0].co;
                last_ov  = q[0].ov;
            end else begin
                chk("sum retained", bus.sum, last_sum);
                chk("carry_out retained", bus.carry_out, last_co);
                chk("overflow retained", bus.overflow, last_ov);
            end
        end
    end

    task automatic send(logic [31:0] a, logic [31:0] b, logic cin, logic s, output int tries);
        logic acc;
        bus.op_a = a; bus.op_b = b; bus.carry_in = cin; bus.sub = s;
        bus.in_valid = 1'b1;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 50) begin
            @(posedge clk);
            acc = bus.in_ready;
            tries++;
        end
        if (!acc) chk("accept timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op_a = $urandom; bus.op_b = $urandom;
        bus.carry_in = 1'($urandom_range(0, 1)); bus.sub = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("result timeout", bus.out_valid, 1);
    endtask

    task automatic receive(int hold, logic [31:0] es, logic eco, logic eov);
        wait_valid();
        chk("lit sum", bus.sum, es);
        chk("lit carry_out", bus.carry_out, eco);
        chk("lit overflow", bus.overflow, eov);
        repeat (hold) begin
            @(negedge clk);
            chk("hold out_valid", bus.out_valid, 1);
            chk("hold sum", bus.sum, es);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("xfer out_valid low", bus.out_valid, 0);
        chk("xfer in_ready", bus.in_ready, 1);
    endtask

    initial begin
        int tries;
        bus.in_valid = 0; bus.op_a = 0; bus.op_b = 0;
        bus.carry_in = 0; bus.sub = 0; bus.out_ready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, tries);
        chk("first accept", tries, 1);
        receive(0, 32'h0000_0100, 1'b0, 1'b0);

        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, tries);
        receive(1, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, tries);
        receive(0, 32'h8000_0000, 1'b0, 1'b1);
        send(32'd5, 32'd7, 1'b0, 1'b1, tries);
        receive(0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send(32'd7, 32'd5, 1'b1, 1'b1, tries);
        receive(0, 32'h0000_0002, 1'b1, 1'b0);

        // Stall in DONE with a competing request pending.
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, tries);
        wait_valid();
        bus.op_a = 32'hA000_0000; bus.op_b = 32'h0000_000F;
        bus.carry_in = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall out_valid", bus.out_valid, 1);
            chk("stall in_ready", bus.in_ready, 0);
            chk("stall sum", bus.sum, 32'h3333_3333);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("stall xfer out_valid", bus.out_valid, 0);
        chk("stall xfer in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("late accept busy", bus.busy, 1);
        receive(0, 32'hA000_000F, 1'b0, 1'b0);

        // Abort during the second RUN cycle.
        send(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, tries);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort in_ready", bus.in_ready, 1);
        chk("abort out_valid", bus.out_valid, 0);
        chk("abort busy", bus.busy, 0);
        chk("abort sum", bus.sum, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, tries);
        receive(0, 32'h2345_6789, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tries);
            wait_valid();
            repeat (i % 3) @(negedge clk);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
